uarc_bus_arbiter: RTL

- Shares one UARC receiver bus (kill/incept/send/stream plus data/permission/address words) between SENDERS requesting cores.
- Sits between the sender-side bus outputs of several core0 instances and the receiver-side inputs of one core.
- Grants the bus round-robin, forwards the owner's request and words to the receiver, and routes acks back only to the owner.
- Caps the owner at MAX_TRANSFERS acked handshakes per grant when others are waiting.

---
 rtl/uarc_bus_arbiter_if.sv | 66 ++++++
 rtl/uarc_bus_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uarc_bus_arbiter_if.sv
// UARC receiver-bus sharing interface: per-sender request side
// and the single receiver side of the arbiter.
interface uarc_bus_arbiter_if #(
  parameter int WORD_MAG = 5,
  parameter int SENDERS  = 4
);
  localparam int WW = 1 << WORD_MAG;

  logic [SENDERS-1:0] snd_kills;
  logic [SENDERS-1:0] snd_incepts;
  logic [SENDERS-1:0] snd_sends;
  logic [SENDERS-1:0] snd_streams;
  logic [SENDERS-1:0][WW-1:0] snd_datas;
  logic [SENDERS-1:0][WW-1:0] snd_self_permissions;
  logic [SENDERS-1:0][WW-1:0] snd_self_addresses;
  logic [SENDERS-1:0][WW-1:0] snd_incept_permissions;
  logic [SENDERS-1:0][WW-1:0] snd_incept_addresses;
  logic [SENDERS-1:0] snd_kill_acks;
  logic [SENDERS-1:0] snd_incept_acks;
  logic [SENDERS-1:0] snd_send_acks;
  logic [SENDERS-1:0] snd_stream_acks;
  logic [SENDERS-1:0] snd_grants;

  logic          rcv_enable;
  logic          rcv_kill;
  logic          rcv_incept;
  logic          rcv_send;
  logic          rcv_stream;
  logic [WW-1:0] rcv_data;
  logic [WW-1:0] rcv_self_permission;
  logic [WW-1:0] rcv_self_address;
  logic [WW-1:0] rcv_incept_permission;
  logic [WW-1:0] rcv_incept_address;
  logic          rcv_kill_ack;
  logic          rcv_incept_ack;
  logic          rcv_send_ack;
  logic          rcv_stream_ack;

  modport slave (
    input  snd_kills, snd_incepts, snd_sends, snd_streams,
    input  snd_datas, snd_self_permissions, snd_self_addresses,
    input  snd_incept_permissions, snd_incept_addresses,
    output snd_kill_acks, snd_incept_acks,
    output snd_send_acks, snd_stream_acks, snd_grants,
    input  rcv_enable,
    output rcv_kill, rcv_incept, rcv_send, rcv_stream,
    output rcv_data, rcv_self_permission, rcv_self_address,
    output rcv_incept_permission, rcv_incept_address,
    input  rcv_kill_ack, rcv_incept_ack,
    input  rcv_send_ack, rcv_stream_ack
  );

  modport master (
    output snd_kills, snd_incepts, snd_sends, snd_streams,
    output snd_datas, snd_self_permissions, snd_self_addresses,
    output snd_incept_permissions, snd_incept_addresses,
    input  snd_kill_acks, snd_incept_acks,
    input  snd_send_acks, snd_stream_acks, snd_grants,
    output rcv_enable,
    input  rcv_kill, rcv_incept, rcv_send, rcv_stream,
    input  rcv_data, rcv_self_permission, rcv_self_address,
    input  rcv_incept_permission, rcv_incept_address,
    output rcv_kill_ack, rcv_incept_ack,
    output rcv_send_ack, rcv_stream_ack
  );
endinterface

// File: rtl/uarc_bus_arbiter.sv
// Round-robin arbiter sharing one UARC receiver bus between
// several senders, with a per-grant burst cap under contention.
module uarc_bus_arbiter #(
  parameter int WORD_MAG      = 5,
  parameter int SENDERS       = 4,
  parameter int MAX_TRANSFERS = 8
) (
  input logic               clk,
  input logic               reset,
  uarc_bus_arbiter_if.slave bus
);
  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int OW = $clog2(SENDERS);
  localparam int CW = $clog2(MAX_TRANSFERS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_TRANSFERS);
  localparam logic [OW-1:0] OLAST = OW'(SENDERS - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      r_rr_ptr;
  logic [OW-1:0]      w_pick;
  logic [OW-1:0]      w_rr_nx;
  logic [CW-1:0]      r_xfer_cnt;
  logic [CW:0]        w_cnt_inc;
  logic [SENDERS-1:0] r_grants;
  logic [SENDERS-1:0] w_req;
  logic [SENDERS-1:0] w_oh;
  int                 w_idx;

  logic w_any;
  logic w_granted;
  logic w_start;
  logic w_release;
  logic w_ack;
  logic w_cap;
  logic w_others;
  logic w_kill;
  logic w_incept;
  logic w_send;
  logic w_stream;

  logic [WORD_WIDTH-1:0] w_data;
  logic [WORD_WIDTH-1:0] w_sperm;
  logic [WORD_WIDTH-1:0] w_saddr;
  logic [WORD_WIDTH-1:0] w_iperm;
  logic [WORD_WIDTH-1:0] w_iaddr;

  assign w_req = bus.snd_kills | bus.snd_incepts
               | bus.snd_sends | bus.snd_streams;
  assign w_oh  = SENDERS'(1) << r_owner;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int k = 0; k < SENDERS; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= SENDERS) w_idx = w_idx - SENDERS;
      if (!w_any && w_req[w_idx[OW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[OW-1:0];
      end
    end
  end

  assign w_granted = (r_state == GRANTED);
  assign w_start   = (r_state == IDLE) & bus.rcv_enable & w_any;
  assign w_ack     = (w_kill   & bus.rcv_kill_ack)
                   | (w_incept & bus.rcv_incept_ack)
                   | (w_send   & bus.rcv_send_ack)
                   | (w_stream & bus.rcv_stream_ack);
  assign w_cnt_inc = {1'b0, r_xfer_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_cap     = (w_cnt_inc >= {1'b0, CMAX});
  assign w_others  = |(w_req & ~w_oh);
  assign w_release = w_granted & (~w_req[r_owner]
                   | (w_ack & w_cap & w_others));
  assign w_rr_nx   = (r_owner == OLAST) ? '0 : r_owner + OW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_start)   w_state_nx = GRANTED;
      GRANTED: if (w_release) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_kill   = 1'b0;
    w_incept = 1'b0;
    w_send   = 1'b0;
    w_stream = 1'b0;
    w_data   = '0;
    w_sperm  = '0;
    w_saddr  = '0;
    w_iperm  = '0;
    w_iaddr  = '0;
    if (w_granted) begin
      w_data  = bus.snd_datas[r_owner];
      w_sperm = bus.snd_self_permissions[r_owner];
      w_saddr = bus.snd_self_addresses[r_owner];
      w_iperm = bus.snd_incept_permissions[r_owner];
      w_iaddr = bus.snd_incept_addresses[r_owner];
      if (bus.rcv_enable) begin
        if (bus.snd_kills[r_owner])        w_kill   = 1'b1;
        else if (bus.snd_incepts[r_owner]) w_incept = 1'b1;
        else if (bus.snd_sends[r_owner])   w_send   = 1'b1;
        else if (bus.snd_streams[r_owner]) w_stream = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_xfer_cnt <= '0;
      r_grants   <= '0;
    end else if (w_start) begin
      r_owner    <= w_pick;
      r_xfer_cnt <= '0;
      r_grants   <= SENDERS'(1) << w_pick;
    end else if (w_release) begin
      r_rr_ptr   <= w_rr_nx;
      r_grants   <= '0;
    end else if (w_ack && r_xfer_cnt != CMAX) begin
      r_xfer_cnt <= w_cnt_inc[CW-1:0];
    end
  end

  assign bus.rcv_kill   = w_kill;
  assign bus.rcv_incept = w_incept;
  assign bus.rcv_send   = w_send;
  assign bus.rcv_stream = w_stream;

  assign bus.rcv_data              = w_data;
  assign bus.rcv_self_permission   = w_sperm;
  assign bus.rcv_self_address      = w_saddr;
  assign bus.rcv_incept_permission = w_iperm;
  assign bus.rcv_incept_address    = w_iaddr;

  assign bus.snd_kill_acks =
    w_oh & {SENDERS{w_kill & bus.rcv_kill_ack}};
  assign bus.snd_incept_acks =
    w_oh & {SENDERS{w_incept & bus.rcv_incept_ack}};
  assign bus.snd_send_acks =
    w_oh & {SENDERS{w_send & bus.rcv_send_ack}};
  assign bus.snd_stream_acks =
    w_oh & {SENDERS{w_stream & bus.rcv_stream_ack}};
  assign bus.snd_grants = r_grants;
endmodule
